// File: rtl/mdu_pkg.sv
// Shared MIPS decode types for the multiply/divide unit.
package mips_decls_p;

  typedef enum logic [5:0] {
    F_SLL   = 6'h00,
    F_MFHI  = 6'h10,
    F_MTHI  = 6'h11,
    F_MFLO  = 6'h12,
    F_MTLO  = 6'h13,
    F_MULT  = 6'h18,
    F_MULTU = 6'h19,
    F_DIV   = 6'h1A,
    F_DIVU  = 6'h1B,
    F_ADD   = 6'h20
  } funct_t;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    SIGN,
    DONE
  } mdu_state_t;

  typedef enum logic [2:0] {
    MDU_NONE,
    MDU_MUL,
    MDU_DIV,
    MDU_MFHI,
    MDU_MFLO,
    MDU_MTHI,
    MDU_MTLO
  } mdu_op_t;

endpackage

// File: rtl/mdu_decode.sv
// Maps an R-type funct code to an MDU operation and a signed flag.
module mdu_decode
  import mips_decls_p::*;
(
  input  funct_t  i_funct,
  output mdu_op_t o_op,
  output logic    o_signed
);

  // Pure decode; anything that is not an MDU funct becomes MDU_NONE.
  always_comb begin
    o_op     = MDU_NONE;
    o_signed = 1'b0;
    case (i_funct)
      F_MULT:  begin o_op = MDU_MUL; o_signed = 1'b1; end
      F_MULTU: o_op = MDU_MUL;
      F_DIV:   begin o_op = MDU_DIV; o_signed = 1'b1; end
      F_DIVU:  o_op = MDU_DIV;
      F_MFHI:  o_op = MDU_MFHI;
      F_MFLO:  o_op = MDU_MFLO;
      F_MTHI:  o_op = MDU_MTHI;
      F_MTLO:  o_op = MDU_MTLO;
      default: o_op = MDU_NONE;
    endcase
  end

endmodule

// File: rtl/mdu.sv
// Iterative multiply/divide unit owning HI/LO; one operand bit per cycle.
module mdu
  import mips_decls_p::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  funct_t           funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             done,
  output logic             stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam int unsigned AW = 2 * WIDTH;

  mdu_state_t       r_state;
  logic [AW-1:0]    r_acc;
  logic [WIDTH-1:0] r_bmag;
  logic [CW-1:0]    r_cnt;
  logic             r_div;
  logic             r_sa;
  logic             r_sb;
  logic             r_div0;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  mdu_op_t          w_op;
  logic             w_signed;
  logic             w_sa;
  logic             w_sb;
  logic [WIDTH-1:0] w_amag;
  logic [WIDTH-1:0] w_bmag;
  logic             w_accept;
  logic [CW-1:0]    w_cnt_nxt;
  logic [WIDTH-1:0] w_addend;
  logic [WIDTH:0]   w_sum;
  logic [AW-1:0]    w_mul_nxt;
  logic [WIDTH:0]   w_rem_sh;
  logic             w_ge;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_rem_new;
  logic [AW-1:0]    w_div_nxt;
  logic [AW-1:0]    w_prod_fix;
  logic [WIDTH-1:0] w_quo;
  logic [WIDTH-1:0] w_rem;
  logic [WIDTH-1:0] w_quo_fix;
  logic [WIDTH-1:0] w_rem_fix;

  mdu_decode u_decode (
    .i_funct  (funct),
    .o_op     (w_op),
    .o_signed (w_signed)
  );

  assign busy  = (r_state == CALC) || (r_state == SIGN);
  assign done  = (r_state == DONE);
  assign stall = start & busy;
  assign hi    = r_hi;
  assign lo    = r_lo;

  // Operand magnitudes; the signs are reapplied in SIGN.
  assign w_sa     = w_signed & a[WIDTH-1];
  assign w_sb     = w_signed & b[WIDTH-1];
  assign w_amag   = w_sa ? -a : a;
  assign w_bmag   = w_sb ? -b : b;
  assign w_accept = start & ~busy;
  assign w_cnt_nxt = r_cnt + CW'(1);

  // Shift-add step: multiplier in the low half, partial product in the high half.
  assign w_addend  = r_acc[0] ? r_bmag : '0;
  assign w_sum     = {1'b0, r_acc[AW-1:WIDTH]} + {1'b0, w_addend};
  assign w_mul_nxt = {w_sum, r_acc[WIDTH-1:1]};

  // Restoring division step: remainder in the high half, dividend/quotient low.
  assign w_rem_sh  = r_acc[AW-1:WIDTH-1];
  assign w_ge      = (w_rem_sh >= {1'b0, r_bmag});
  assign w_diff    = WIDTH'(w_rem_sh - {1'b0, r_bmag});
  assign w_rem_new = w_ge ? w_diff : WIDTH'(w_rem_sh);
  assign w_div_nxt = {w_rem_new, r_acc[WIDTH-2:0], w_ge};

  // Sign fix-up; divide by zero keeps all-ones quotient, remainder fix restores a.
  assign w_prod_fix = (r_sa ^ r_sb) ? -r_acc : r_acc;
  assign w_quo      = r_acc[WIDTH-1:0];
  assign w_rem      = r_acc[AW-1:WIDTH];
  assign w_quo_fix  = r_div0 ? '1 : ((r_sa ^ r_sb) ? -w_quo : w_quo);
  assign w_rem_fix  = r_sa ? -w_rem : w_rem;

  // MFHI/MFLO read path, straight from the registers.
  always_comb begin
    result = '0;
    case (w_op)
      MDU_MFHI: result = r_hi;
      MDU_MFLO: result = r_lo;
      default:  result = '0;
    endcase
  end

  // Control FSM plus HI/LO and iteration datapath.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_acc   <= '0;
      r_bmag  <= '0;
      r_cnt   <= '0;
      r_div   <= 1'b0;
      r_sa    <= 1'b0;
      r_sb    <= 1'b0;
      r_div0  <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          r_state <= IDLE;
          if (w_accept) begin
            case (w_op)
              MDU_MUL, MDU_DIV: begin
                r_state <= CALC;
                r_div   <= (w_op == MDU_DIV);
                r_sa    <= w_sa;
                r_sb    <= w_sb;
                r_div0  <= (w_op == MDU_DIV) && (b == '0);
                r_acc   <= {{WIDTH{1'b0}}, w_amag};
                r_bmag  <= w_bmag;
                r_cnt   <= '0;
              end
              MDU_MTHI: r_hi <= a;
              MDU_MTLO: r_lo <= a;
              default: ;
            endcase
          end
        end
        CALC: begin
          r_acc <= r_div ? w_div_nxt : w_mul_nxt;
          r_cnt <= w_cnt_nxt;
          if (w_cnt_nxt == CW'(WIDTH)) begin
            r_state <= SIGN;
          end
        end
        SIGN: begin
          if (r_div) begin
            r_hi <= w_rem_fix;
            r_lo <= w_quo_fix;
          end else begin
            {r_hi, r_lo} <= w_prod_fix;
          end
          r_state <= DONE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu.sv
// Scoreboard bench for mdu: stimulus pushes expected HI/LO, a monitor checks on done.
module tb_mdu;
  import mips_decls_p::*;

  localparam int unsigned W = 32;

  typedef struct {
    funct_t      f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] ehi;
    logic [31:0] elo;
  } vec_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  funct_t       funct;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] result;
  logic         busy;
  logic         done;
  logic         stall;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int           n_checks = 0;
  int           n_fail   = 0;
  logic [63:0]  exp_q[$];
  logic [63:0]  mon_e;
  vec_t         vecs[8];

  always #5 clk = ~clk;

  mdu #(.WIDTH(W)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .funct  (funct),
    .a      (a),
    .b      (b),
    .result (result),
    .busy   (busy),
    .done   (done),
    .stall  (stall),
    .hi     (hi),
    .lo     (lo)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one MULT/DIV request and follow it to its done cycle.
  task automatic run_op(input funct_t f, input logic [31:0] va, input logic [31:0] vb,
                        input logic [31:0] ehi, input logic [31:0] elo);
    int cyc;
    int busy_cnt;
    int done_cyc;
    start = 1'b1;
    funct = f;
    a     = va;
    b     = vb;
    exp_q.push_back({ehi, elo});
    tick();
    start    = 1'b0;
    cyc      = 1;
    busy_cnt = 0;
    done_cyc = -1;
    while (cyc <= 60 && done_cyc < 0) begin
      if (done) done_cyc = cyc;
      else begin
        if (busy) busy_cnt++;
        tick();
        cyc++;
      end
    end
    chk("done_cycle", 64'(done_cyc), 64'd34);
    chk("busy_cycles", 64'(busy_cnt), 64'd33);
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset === 1'b0 && done === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 64'(done), 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("hi", 64'(hi), 64'(mon_e[63:32]));
        chk("lo", 64'(lo), 64'(mon_e[31:0]));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int stall_cnt;
    int done_seen;

    vecs[0] = '{F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[1] = '{F_MULT,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1};
    vecs[2] = '{F_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3] = '{F_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[4] = '{F_DIVU,  32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF};
    vecs[5] = '{F_DIV,   32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF};
    vecs[6] = '{F_DIVU,  32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E};
    vecs[7] = '{F_MULTU, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780};

    reset = 1'b1;
    start = 1'b0;
    funct = F_SLL;
    a     = '0;
    b     = '0;
    repeat (3) tick();
    chk("reset_hi", 64'(hi), 64'd0);
    chk("reset_lo", 64'(lo), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    reset = 1'b0;
    tick();

    // Back-to-back: each request is issued in the previous one's done cycle.
    foreach (vecs[i]) run_op(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].ehi, vecs[i].elo);
    start = 1'b0;
    tick();
    chk("idle_busy", 64'(busy), 64'd0);
    chk("idle_done", 64'(done), 64'd0);

    // MTLO is visible one cycle later; HI untouched.
    start = 1'b1;
    funct = F_MTLO;
    a     = 32'h0000CAFE;
    tick();
    chk("mtlo_lo", 64'(lo), 64'h0000CAFE);
    chk("mtlo_hi", 64'(hi), 64'h00000001);
    funct = F_MFLO;
    #1;
    chk("mflo_result", 64'(result), 64'h0000CAFE);
    chk("mflo_stall", 64'(stall), 64'd0);
    funct = F_MFHI;
    #1;
    chk("mfhi_result", 64'(result), 64'h00000001);
    funct = F_ADD;
    a     = 32'h0000DEAD;
    #1;
    chk("nonmdu_result", 64'(result), 64'd0);
    tick();
    chk("nonmdu_hi", 64'(hi), 64'h00000001);
    chk("nonmdu_lo", 64'(lo), 64'h0000CAFE);
    chk("nonmdu_busy", 64'(busy), 64'd0);
    start = 1'b0;

    // MFLO held from cycle 5 of a DIV stalls until the done cycle.
    start = 1'b1;
    funct = F_DIV;
    a     = 32'd100;
    b     = 32'd7;
    exp_q.push_back({32'd2, 32'd14});
    tick();
    start = 1'b0;
    repeat (4) tick();
    start     = 1'b1;
    funct     = F_MFLO;
    stall_cnt = 0;
    for (int c = 5; c <= 33; c++) begin
      #1;
      if (stall) stall_cnt++;
      tick();
    end
    chk("stall_cycles", 64'(stall_cnt), 64'd29);
    chk("stall_done", 64'(done), 64'd1);
    chk("stall_release", 64'(stall), 64'd0);
    chk("stall_result", 64'(result), 64'd14);
    funct = F_MTHI;
    a     = 32'h00001234;
    tick();
    start = 1'b0;
    chk("mthi_hi", 64'(hi), 64'h00001234);
    chk("mthi_lo", 64'(lo), 64'd14);

    // Reset in cycle 10 of a MULT aborts it with no done pulse.
    start = 1'b1;
    funct = F_MULT;
    a     = 32'd3;
    b     = 32'd5;
    tick();
    start = 1'b0;
    repeat (9) tick();
    reset = 1'b1;
    tick();
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_hi", 64'(hi), 64'd0);
    chk("abort_lo", 64'(lo), 64'd0);
    reset     = 1'b0;
    done_seen = 0;
    repeat (40) begin
      tick();
      if (done) done_seen++;
    end
    chk("abort_no_done", 64'(done_seen), 64'd0);

    repeat (2) tick();
    chk("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
